// File: rtl/moving_avg_op.sv
// Sliding-window moving average: WIN = 2**LOG2_WIN sample circular buffer with a running sum.
// Optional macro MAVG_ROUND_EN selects round-half-up output instead of floor.
module moving_avg_op #(
    parameter int DATA_W   = 32,
    parameter int LOG2_WIN = 3
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                clear,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_data,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    output logic [LOG2_WIN:0]   fill_cnt,
    output logic                full
);

    localparam int WIN   = 1 << LOG2_WIN;
    localparam int SUM_W = DATA_W + LOG2_WIN;

    localparam logic [LOG2_WIN:0]   WIN_C   = (LOG2_WIN+1)'(WIN);
    localparam logic [LOG2_WIN:0]   CNT_ONE = (LOG2_WIN+1)'(1);
    localparam logic [LOG2_WIN-1:0] PTR_ONE = LOG2_WIN'(1);

    logic [DATA_W-1:0]   buf_r [WIN];
    logic [LOG2_WIN-1:0] wr_ptr_r;
    logic [LOG2_WIN:0]   fill_cnt_r;
    logic [SUM_W-1:0]    sum_r;
    logic [DATA_W-1:0]   out_data_r;
    logic                out_valid_r;

    logic                full_s;
    logic [SUM_W-1:0]    in_ext_s;
    logic [SUM_W-1:0]    evict_ext_s;
    logic [SUM_W-1:0]    sum_next_s;
    logic [LOG2_WIN-1:0] ptr_next_s;
    logic [LOG2_WIN-1:0] wr_idx_s;
    logic [LOG2_WIN:0]   fill_next_s;
    logic [DATA_W-1:0]   mean_s;
`ifdef MAVG_ROUND_EN
    logic [DATA_W:0]     rnd_s;
`endif

    assign full_s    = (fill_cnt_r == WIN_C);
    assign full      = full_s;
    assign fill_cnt  = fill_cnt_r;
    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;

    // Next-state for sum, pointer and fill count; evicted sample is the slot about to be overwritten.
    always_comb begin
        in_ext_s    = {{LOG2_WIN{in_data[DATA_W-1]}}, in_data};
        evict_ext_s = '0;
        sum_next_s  = sum_r;
        ptr_next_s  = wr_ptr_r;
        fill_next_s = fill_cnt_r;
        wr_idx_s    = wr_ptr_r;
        if (full_s) begin
            evict_ext_s = {{LOG2_WIN{buf_r[wr_ptr_r][DATA_W-1]}}, buf_r[wr_ptr_r]};
        end else begin
            evict_ext_s = '0;
        end
        if (clear) begin
            wr_idx_s = '0;
            if (in_valid) begin
                sum_next_s  = in_ext_s;
                ptr_next_s  = PTR_ONE;
                fill_next_s = CNT_ONE;
            end else begin
                sum_next_s  = '0;
                ptr_next_s  = '0;
                fill_next_s = '0;
            end
        end else if (in_valid) begin
            sum_next_s = sum_r + in_ext_s - evict_ext_s;
            ptr_next_s = wr_ptr_r + PTR_ONE;
            if (full_s) begin
                fill_next_s = fill_cnt_r;
            end else begin
                fill_next_s = fill_cnt_r + CNT_ONE;
            end
        end else begin
            sum_next_s  = sum_r;
            ptr_next_s  = wr_ptr_r;
            fill_next_s = fill_cnt_r;
        end
    end

    // Mean of the updated sum; rounding adds the bit just below the shift point.
    always_comb begin
`ifdef MAVG_ROUND_EN
        rnd_s = {sum_next_s[SUM_W-1], sum_next_s[SUM_W-1:LOG2_WIN]}
              + {{DATA_W{1'b0}}, sum_next_s[LOG2_WIN-1]};
        if (!rnd_s[DATA_W] && rnd_s[DATA_W-1]) begin
            mean_s = {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            mean_s = rnd_s[DATA_W-1:0];
        end
`else
        mean_s = sum_next_s[SUM_W-1:LOG2_WIN];
`endif
    end

    // Window state, buffer and registered result.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < WIN; i++) begin
                buf_r[i] <= '0;
            end
            wr_ptr_r    <= '0;
            fill_cnt_r  <= '0;
            sum_r       <= '0;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
        end else begin
            if (in_valid) begin
                buf_r[wr_idx_s] <= in_data;
                out_data_r      <= mean_s;
            end else begin
                out_data_r      <= out_data_r;
            end
            wr_ptr_r    <= ptr_next_s;
            fill_cnt_r  <= fill_next_s;
            sum_r       <= sum_next_s;
            out_valid_r <= in_valid;
        end
    end

endmodule

// File: tb/tb_moving_avg_op.sv
// Scoreboard bench for moving_avg_op (WIN=8): the driver queues hand-computed means,
// the monitor pops one on every out_valid pulse.
module tb_moving_avg_op;

`ifdef MAVG_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic        Clk;
    logic        Rst;
    logic        clear;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_valid;
    logic [31:0] out_data;
    logic [3:0]  fill_cnt;
    logic        full;

    logic [31:0] exp_q [$];
    int          n_vec = 0;
    int          n_bad = 0;

    moving_avg_op #(.DATA_W(32), .LOG2_WIN(3)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .clear    (clear),
        .in_valid (in_valid),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_data (out_data),
        .fill_cnt (fill_cnt),
        .full     (full)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic sample(input logic clr, input logic [31:0] d,
                          input logic [31:0] ef, input logic [31:0] er);
        @(negedge Clk);
        clear    = clr;
        in_valid = 1'b1;
        in_data  = d;
        exp_q.push_back(ROUND ? er : ef);
    endtask

    task automatic idle();
        @(negedge Clk);
        clear    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic clr_only();
        @(negedge Clk);
        clear    = 1'b1;
        in_valid = 1'b0;
    endtask

    // Monitor: every out_valid pulse must match the oldest queued expectation.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge Clk);
            if (out_valid === 1'b1) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_out_valid: got data 0x%08h expected no pulse", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        n_bad++;
                        $display("FAIL out_data: got 0x%08h expected 0x%08h", out_data, e);
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] t2_f [8] = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 32'd2, 32'd3, 32'd4};
        logic [31:0] t2_r [8] = '{32'd0, 32'd0, 32'd1, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
        logic [31:0] t4_f [7] = '{-32'sd1, -32'sd1, -32'sd2, -32'sd2, -32'sd2, -32'sd3, -32'sd3};
        logic [31:0] t4_r [7] = '{32'sd0, -32'sd1, -32'sd1, -32'sd2, -32'sd2, -32'sd2, -32'sd3};
        logic [31:0] t6_f [8] = '{32'h0FFF_FFFF, 32'h1FFF_FFFF, 32'h2FFF_FFFF, 32'h3FFF_FFFF,
                                  32'h4FFF_FFFF, 32'h5FFF_FFFF, 32'h6FFF_FFFF, 32'h7FFF_FFFF};
        logic [31:0] t6_r [8] = '{32'h1000_0000, 32'h2000_0000, 32'h3000_0000, 32'h4000_0000,
                                  32'h4FFF_FFFF, 32'h5FFF_FFFF, 32'h6FFF_FFFF, 32'h7FFF_FFFF};
        logic [31:0] t6_n [8] = '{32'hF000_0000, 32'hE000_0000, 32'hD000_0000, 32'hC000_0000,
                                  32'hB000_0000, 32'hA000_0000, 32'h9000_0000, 32'h8000_0000};

        Rst      = 1'b1;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_data  = 32'd0;

        // 1: reset state
        repeat (2) @(negedge Clk);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_fill_cnt", {28'd0, fill_cnt}, 32'd0);
        chk("rst_full", {31'd0, full}, 32'd0);
        Rst = 1'b0;

        // 2: clear then samples 1..8
        clr_only();
        for (int i = 0; i < 8; i++) sample(1'b0, 32'(i + 1), t2_f[i], t2_r[i]);
        idle();
        chk("t2_fill_cnt", {28'd0, fill_cnt}, 32'd8);
        chk("t2_full", {31'd0, full}, 32'd1);
        chk("t2_out_data", out_data, ROUND ? 32'd5 : 32'd4);

        // 3: wrap and eviction (9 evicts 1, 10 evicts 2), then hold
        sample(1'b0, 32'd9, 32'd5, 32'd6);
        sample(1'b0, 32'd10, 32'd6, 32'd7);
        idle();
        idle();
        chk("t3_hold", out_data, ROUND ? 32'd7 : 32'd6);

        // 4: clear alone, then negative samples
        clr_only();
        idle();
        chk("t4_clr_fill", {28'd0, fill_cnt}, 32'd0);
        chk("t4_clr_full", {31'd0, full}, 32'd0);
        chk("t4_clr_hold", out_data, ROUND ? 32'd7 : 32'd6);
        sample(1'b0, -32'sd1, -32'sd1, 32'd0);
        for (int i = 0; i < 7; i++) sample(1'b0, -32'sd3, t4_f[i], t4_r[i]);
        idle();
        chk("t4_fill_cnt", {28'd0, fill_cnt}, 32'd8);

        // 5: clear+in_valid mid-window, then flush the 100 out
        sample(1'b1, 32'd10, 32'd1, 32'd1);
        sample(1'b0, 32'd10, 32'd2, 32'd3);
        sample(1'b0, 32'd10, 32'd3, 32'd4);
        sample(1'b0, 32'd10, 32'd5, 32'd5);
        sample(1'b0, 32'd10, 32'd6, 32'd6);
        idle();
        chk("t5_fill5", {28'd0, fill_cnt}, 32'd5);
        sample(1'b1, 32'd100, 32'd12, 32'd13);
        idle();
        chk("t5_fill1", {28'd0, fill_cnt}, 32'd1);
        chk("t5_not_full", {31'd0, full}, 32'd0);
        for (int i = 0; i < 7; i++) sample(1'b0, 32'd0, 32'd12, 32'd13);
        sample(1'b0, 32'd0, 32'd0, 32'd0);
        idle();
        chk("t5_full", {31'd0, full}, 32'd1);
        chk("t5_out_zero", out_data, 32'd0);

        // 6: extremes, then reset mid-stream
        for (int i = 0; i < 8; i++) sample(i == 0, 32'h7FFF_FFFF, t6_f[i], t6_r[i]);
        for (int i = 0; i < 8; i++) sample(i == 0, 32'h8000_0000, t6_n[i], t6_n[i]);
        @(negedge Clk);
        Rst      = 1'b1;
        clear    = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'd5;
        @(negedge Clk);
        Rst      = 1'b0;
        in_valid = 1'b0;
        chk("t6_rst_out_data", out_data, 32'd0);
        chk("t6_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_rst_fill", {28'd0, fill_cnt}, 32'd0);
        chk("t6_rst_full", {31'd0, full}, 32'd0);
        sample(1'b0, 32'd16, 32'd2, 32'd2);
        idle();
        chk("t6_restart_fill", {28'd0, fill_cnt}, 32'd1);
        chk("t6_restart_data", out_data, 32'd2);

        repeat (3) idle();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
